dmem_dma_copy: RTL and testbench

- Bus-initiator block that drives the data-memory port (we, a, wd) and samples its combinational read data (rd). Moves a block of 32-bit words from a source address to a destination address without the processor.
- Source and destination may be RAM or the memory-mapped peripherals: switches at 0xC000_0000 (read) and LEDs at 0xC000_0004 (write).
- Shares the memory port with the core through a simple request/grant handshake. The top-level mux is external to this block.

---
 rtl/dmem_dma_pkg.sv | 22 ++
 rtl/dmem_dma_copy.sv | 135 +++++++++++++
 tb/tb_dmem_dma_copy.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_dma_pkg.sv
// Shared types and helpers for the data-memory block-copy engine.
// The engine moves 32-bit words between RAM and the memory-mapped switch/LED registers.
package dmem_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [31:0] SW_ADDR_DEFAULT  = 32'hC000_0000;
  localparam logic [31:0] LED_ADDR_DEFAULT = 32'hC000_0004;

  // Peripheral registers are single words, so a pointer parked on one must not advance.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic fixed);
    return fixed ? addr : addr + 32'd4;
  endfunction

endpackage

// File: rtl/dmem_dma_copy.sv
// Block-copy initiator on the data-memory port: one read then one write per word,
// each taken only in a cycle where the shared port is granted.
module dmem_dma_copy
  import dmem_dma_pkg::*;
#(
  parameter int          LEN_W    = 8,
  parameter logic [31:0] SW_ADDR  = SW_ADDR_DEFAULT,
  parameter logic [31:0] LED_ADDR = LED_ADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  state_e           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_count;
  logic [31:0]      r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_req;

  logic             w_misaligned;
  logic             w_rd_go;
  logic             w_wr_go;

  assign w_misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  assign w_rd_go      = (r_state == ST_READ)  && bus_gnt;
  assign w_wr_go      = (r_state == ST_WRITE) && bus_gnt;

  // NOTE: every state register uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_misaligned) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else if (len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_src   <= src_addr;
              r_dst   <= dst_addr;
              r_count <= len;
              r_req   <= 1'b1;
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus_gnt) r_state <= ST_READ;
        end
        ST_READ: begin
          if (bus_gnt) begin
            r_data  <= mem_rd;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus_gnt) begin
            r_count <= r_count - LEN_W'(1);
            r_src   <= next_addr(r_src, r_src == SW_ADDR);
            r_dst   <= next_addr(r_dst, r_dst == LED_ADDR);
            if (r_count == LEN_W'(1)) begin
              r_state <= ST_DONE;
              r_req   <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign bus_req = r_req;

  // The port is driven only in a granted cycle, so a stalled cycle presents an idle bus.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (w_rd_go) begin
      mem_a = r_src;
    end else if (w_wr_go) begin
      mem_a  = r_dst;
      mem_wd = r_data;
      mem_we = 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_dma_copy.sv
// Self-checking bench for dmem_dma_copy: RAM/switch/LED environment, a slot-queue
// reference model compared every cycle, and directed transfers with literal expectations.
module tb_dmem_dma_copy;

  localparam int          LEN_W = 8;
  localparam logic [31:0] SW    = 32'hC000_0000;
  localparam logic [31:0] LED   = 32'hC000_0004;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic             start    = 1'b0;
  logic             bus_gnt  = 1'b1;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len      = '0;
  logic             busy, done, err, bus_req, mem_we;
  logic [31:0]      mem_a, mem_wd, mem_rd;

  dmem_dma_copy #(.LEN_W(LEN_W), .SW_ADDR(SW), .LED_ADDR(LED)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment: 64-word RAM, switches, LEDs ----------------
  logic [31:0] ram_init [64];
  logic [31:0] ram_wr   [64];
  bit          ram_wv   [64] = '{default: 1'b0};
  logic [31:0] sw_val   = '0;
  logic [31:0] leds     = '0;

  function automatic logic [31:0] ram_word(input int i);
    return ram_wv[i] ? ram_wr[i] : ram_init[i];
  endfunction

  assign mem_rd = (mem_a == SW) ? sw_val :
                  (ram_wv[mem_a[7:2]] ? ram_wr[mem_a[7:2]] : ram_init[mem_a[7:2]]);

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_a == LED) leds <= mem_wd;
      else begin
        ram_wr[mem_a[7:2]] <= mem_wd;
        ram_wv[mem_a[7:2]] <= 1'b1;
      end
    end
  end

  int stall_from = 0;
  int stall_to   = -1;
  always @(posedge clk) begin
    #1;
    bus_gnt = !((cyc >= stall_from) && (cyc <= stall_to));
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queue of expected bus cycles ----------------
  typedef struct packed {
    logic        gated;   // consumed only in a granted cycle
    logic        chk_wd;
    logic        busy, done, err, req, we;
    logic [31:0] a, wd;
  } slot_t;

  slot_t       exp_q [$];
  logic [31:0] mdl_wr [64];
  bit          mdl_wv [64] = '{default: 1'b0};
  logic [31:0] mdl_leds = '0;

  function automatic slot_t mk(input logic g, input logic cw, input logic b, input logic d,
                               input logic e, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] wd);
    slot_t s;
    s.gated = g; s.chk_wd = cw; s.busy = b; s.done = d; s.err = e;
    s.req = r; s.we = w; s.a = a; s.wd = wd;
    return s;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    if (a == SW) return sw_val;
    return mdl_wv[a[7:2]] ? mdl_wr[a[7:2]] : ram_init[a[7:2]];
  endfunction

  task automatic model_start(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] n);
    logic [31:0] sa, da, w;
    if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0));
      return;
    end
    sa = s;
    da = d;
    if (n != '0) begin
      exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
      for (int k = 0; k < int'(n); k++) begin
        w = mdl_read(sa);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sa, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, da, w));
        if (sa != SW)  sa = sa + 32'd4;
        if (da != LED) da = da + 32'd4;
      end
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
  endtask

  bit chk_en = 1'b0;
  int done_cyc = -1, err_cyc = -1;
  int n_done = 0, n_err = 0, n_req = 0, n_we = 0, n_busy = 0;
  int wr_cyc [$];

  always @(negedge clk) begin : cmp
    slot_t       e;
    bit          pop, accept;
    logic [71:0] act, expv;
    if (chk_en) begin
      accept = (exp_q.size() == 0) && start && !reset;
      pop    = 1'b0;
      if (exp_q.size() == 0)
        e = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      else if (exp_q[0].gated && !bus_gnt)
        e = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      else begin
        e   = exp_q[0];
        pop = 1'b1;
      end
      act  = {busy, done, err, bus_req, mem_we, 3'b000, mem_a, (e.chk_wd ? mem_wd : 32'h0)};
      expv = {e.busy, e.done, e.err, e.req, e.we, 3'b000, e.a, e.wd};
      check($sformatf("cycle %0d bus/status", cyc), act, expv);

      if (pop) begin
        if (e.we) begin
          if (e.a == LED) mdl_leds = e.wd;
          else begin
            mdl_wr[e.a[7:2]] = e.wd;
            mdl_wv[e.a[7:2]] = 1'b1;
          end
        end
        void'(exp_q.pop_front());
      end
      if (reset)       exp_q.delete();
      else if (accept) model_start(src_addr, dst_addr, len);

      if (done)    begin n_done <= n_done + 1; done_cyc <= cyc; end
      if (err)     begin n_err  <= n_err + 1;  err_cyc  <= cyc; end
      if (bus_req) n_req  <= n_req + 1;
      if (busy)    n_busy <= n_busy + 1;
      if (mem_we) begin
        n_we <= n_we + 1;
        wr_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  int t0;
  int s_done, s_err, s_req, s_we, s_busy, s_wr;

  task automatic snap();
    s_done = n_done; s_err = n_err; s_req = n_req;
    s_we = n_we; s_busy = n_busy; s_wr = wr_cyc.size();
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] n);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; src_addr = 32'h0000_0BAD; dst_addr = 32'h0000_0F0F; len = '1;
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    check(name, 72'(act), 72'(exp));
  endtask

  initial begin
    int t_keep;
    for (int i = 0; i < 64; i++) ram_init[i] = 32'h0;
    ram_init[0]  = 32'h11;  ram_init[1] = 32'h22;
    ram_init[2]  = 32'h33;  ram_init[3] = 32'h44;
    ram_init[4]  = 32'h155; ram_init[5] = 32'h0F0;
    ram_init[63] = 32'h63;
    sw_val = 32'h2A5;

    reset = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("reset outputs", {busy, done, err, bus_req, mem_we, 3'b000, mem_a, mem_wd}, 72'h0);

    // zero length: immediate done, no bus activity
    snap(); do_start(32'h0, 32'h40, 8'd0);
    repeat (4) @(posedge clk); #1;
    chk_int("zero done cycle", done_cyc - t0, 1);
    chk_int("zero done count", n_done - s_done, 1);
    chk_int("zero bus_req cycles", n_req - s_req, 0);
    chk_int("zero writes", n_we - s_we, 0);
    chk_int("zero busy cycles", n_busy - s_busy, 1);

    // misaligned source: err pulse only
    snap(); do_start(32'h02, 32'h40, 8'd3);
    repeat (4) @(posedge clk); #1;
    chk_int("misaligned err cycle", err_cyc - t0, 1);
    chk_int("misaligned err count", n_err - s_err, 1);
    chk_int("misaligned done count", n_done - s_done, 0);
    chk_int("misaligned bus_req cycles", n_req - s_req, 0);
    chk_int("misaligned writes", n_we - s_we, 0);

    // reset in cycle 5 of a 4-word copy
    snap(); do_start(32'h0, 32'h40, 8'd4);
    repeat (4) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("post-reset outputs", {busy, done, err, bus_req, mem_we, 3'b000, mem_a, mem_wd}, 72'h0);
    repeat (12) @(posedge clk); #1;
    chk_int("reset abort done count", n_done - s_done, 0);
    chk_int("reset abort writes", n_we - s_we, 2);
    chk_int("reset abort RAM[16]", ram_word(16), 32'h11);
    chk_int("reset abort RAM[18]", ram_word(18), 32'h0);
    chk_int("reset abort RAM[19]", ram_word(19), 32'h0);

    // basic 4-word copy 0x00 -> 0x40
    snap(); do_start(32'h0, 32'h40, 8'd4);
    repeat (12) @(posedge clk); #1;
    chk_int("basic done cycle", done_cyc - t0, 10);
    chk_int("basic busy cycles", n_busy - s_busy, 10);
    chk_int("basic write count", n_we - s_we, 4);
    for (int k = 0; k < 4; k++) begin
      chk_int($sformatf("basic write %0d cycle", k), wr_cyc[s_wr + k] - t0, 3 + 2 * k);
      chk_int($sformatf("basic RAM[%0d]", 16 + k), ram_word(16 + k), 32'h11 * (k + 1));
    end

    // start pulsed while busy is ignored
    snap(); do_start(32'h0, 32'h60, 8'd4);
    t_keep = t0;
    repeat (3) @(posedge clk); #1;
    src_addr = 32'h10; dst_addr = 32'hE0; len = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk_int("busy-start done cycle", done_cyc - t_keep, 10);
    chk_int("busy-start done count", n_done - s_done, 1);
    chk_int("busy-start RAM[24]", ram_word(24), 32'h11);
    chk_int("busy-start RAM[27]", ram_word(27), 32'h44);
    chk_int("busy-start RAM[56]", ram_word(56), 32'h0);

    // grant withheld for 3 cycles during the write of word 1
    snap(); do_start(32'h10, 32'h70, 8'd2);
    stall_from = t0 + 5;
    stall_to   = t0 + 7;
    repeat (12) @(posedge clk); #1;
    stall_from = 0; stall_to = -1;
    chk_int("stall done cycle", done_cyc - t0, 9);
    chk_int("stall write count", n_we - s_we, 2);
    chk_int("stall write 0 cycle", wr_cyc[s_wr] - t0, 3);
    chk_int("stall write 1 cycle", wr_cyc[s_wr + 1] - t0, 8);
    chk_int("stall RAM[28]", ram_word(28), 32'h155);
    chk_int("stall RAM[29]", ram_word(29), 32'h0F0);

    // switches -> RAM, fixed source
    snap(); do_start(SW, 32'h80, 8'd3);
    repeat (10) @(posedge clk); #1;
    chk_int("switch done cycle", done_cyc - t0, 8);
    for (int k = 0; k < 3; k++)
      chk_int($sformatf("switch RAM[%0d]", 32 + k), ram_word(32 + k), 32'h2A5);

    // RAM -> LEDs, fixed destination
    snap(); do_start(32'h10, LED, 8'd2);
    repeat (8) @(posedge clk); #1;
    chk_int("led done cycle", done_cyc - t0, 6);
    chk_int("led write count", n_we - s_we, 2);
    chk_int("led final value", leds, 32'h0F0);

    // source address wraps from 0xFFFF_FFFC to 0
    snap(); do_start(32'hFFFF_FFFC, 32'hA0, 8'd2);
    repeat (8) @(posedge clk); #1;
    chk_int("wrap RAM[40]", ram_word(40), 32'h63);
    chk_int("wrap RAM[41]", ram_word(41), 32'h11);

    chk_int("model queue drained", exp_q.size(), 0);
    chk_int("leds vs model", leds, mdl_leds);
    for (int i = 0; i < 64; i++)
      chk_int($sformatf("RAM[%0d] vs model", i), ram_word(i),
              mdl_wv[i] ? mdl_wr[i] : ram_init[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
